// File: rtl/frame_sched_pkg.sv
// Shared types and helpers for the frame bank scheduler: writer/reader state encodings
// and pointer sizing.
package frame_sched_pkg;

    localparam int unsigned NBANKS_DEF = 4;

    typedef enum logic {
        W_IDLE,
        W_FILL
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_BUSY
    } rd_state_e;

    // Bank index bits plus one wrap bit.
    function automatic int unsigned ptr_width(input int unsigned nbanks);
        return $clog2(nbanks) + 1;
    endfunction

endpackage

// File: rtl/frame_reader_port.sv
// One transmitter's view of the bank ring: offers committed banks in order and advances its
// read pointer when the transmitter reports the bank done.
module frame_reader_port
    import frame_sched_pkg::*;
#(
    parameter int unsigned NBANKS = NBANKS_DEF,
    localparam int unsigned PW = ptr_width(NBANKS),
    localparam int unsigned BW = PW - 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [PW-1:0] wr_ptr,
    input  logic [PW-1:0] wr_ptr_nxt,
    input  logic          done,
    output logic          start,
    output logic [BW-1:0] bank,
    output logic [PW-1:0] pend
);

    rd_state_e     state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;

    // A disabled idle reader shadows the writer so it never holds banks; a bank that was
    // already handed out still completes, then the pointer snaps back to the writer.
    always_comb begin
        ptr_nxt = ptr;
        if (state == R_IDLE) begin
            if (!enable) ptr_nxt = wr_ptr_nxt;
        end else if (done) begin
            ptr_nxt = enable ? ptr + PW'(1) : wr_ptr_nxt;
        end
    end

    // Pending count as it will stand after this edge, so the registered total is never stale.
    assign pend = wr_ptr_nxt - ptr_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= R_IDLE;
            ptr   <= '0;
            bank  <= '0;
            start <= 1'b0;
        end else begin
            ptr   <= ptr_nxt;
            start <= 1'b0;
            case (state)
                R_IDLE: begin
                    if (enable && (wr_ptr != ptr)) begin
                        state <= R_START;
                        bank  <= ptr[BW-1:0];
                        start <= 1'b1;
                    end
                end
                R_START: state <= done ? R_IDLE : R_BUSY;
                R_BUSY:  if (done) state <= R_IDLE;
                default: state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/frame_bank_sched.sv
// Bank scheduler between the frame assembler and the CC/LPC transmitters: grants free banks
// to the writer, offers committed banks to each reader, frees a bank once all readers are done.
module frame_bank_sched
    import frame_sched_pkg::*;
#(
    parameter int unsigned NBANKS = NBANKS_DEF,
    parameter int unsigned OVF_W  = 8,
    localparam int unsigned PW = ptr_width(NBANKS),
    localparam int unsigned BW = PW - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_start,
    input  logic             wr_commit,
    output logic             wr_ack,
    output logic             wr_drop,
    output logic [BW-1:0]    wr_bank,
    output logic             cc_start,
    output logic [BW-1:0]    cc_bank,
    input  logic             cc_done,
    input  logic             lpc_en,
    output logic             lpc_start,
    output logic [BW-1:0]    lpc_bank,
    input  logic             lpc_done,
    output logic [PW-1:0]    frames_pend,
    output logic [OVF_W-1:0] ovf_cnt
);

    wr_state_e     wr_state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_nxt;
    logic [PW-1:0] cc_pend;
    logic [PW-1:0] lpc_pend;
    logic          wr_adv;
    logic          full;

    // A restart in the same cycle wins over a commit.
    assign wr_adv     = (wr_state == W_FILL) && wr_commit && !wr_start;
    assign wr_ptr_nxt = wr_ptr + PW'(wr_adv);
    assign wr_bank    = wr_ptr[BW-1:0];
    assign full       = frames_pend >= PW'(NBANKS);

    frame_reader_port #(
        .NBANKS(NBANKS)
    ) u_cc (
        .clock      (clock),
        .reset      (reset),
        .enable     (1'b1),
        .wr_ptr     (wr_ptr),
        .wr_ptr_nxt (wr_ptr_nxt),
        .done       (cc_done),
        .start      (cc_start),
        .bank       (cc_bank),
        .pend       (cc_pend)
    );

    frame_reader_port #(
        .NBANKS(NBANKS)
    ) u_lpc (
        .clock      (clock),
        .reset      (reset),
        .enable     (lpc_en),
        .wr_ptr     (wr_ptr),
        .wr_ptr_nxt (wr_ptr_nxt),
        .done       (lpc_done),
        .start      (lpc_start),
        .bank       (lpc_bank),
        .pend       (lpc_pend)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_state    <= W_IDLE;
            wr_ptr      <= '0;
            wr_ack      <= 1'b0;
            wr_drop     <= 1'b0;
            ovf_cnt     <= '0;
            frames_pend <= '0;
        end else begin
            wr_ack      <= 1'b0;
            wr_drop     <= 1'b0;
            wr_ptr      <= wr_ptr_nxt;
            frames_pend <= (cc_pend > lpc_pend) ? cc_pend : lpc_pend;
            case (wr_state)
                W_IDLE: begin
                    if (wr_start) begin
                        if (!full) begin
                            wr_state <= W_FILL;
                            wr_ack   <= 1'b1;
                        end else begin
                            wr_drop <= 1'b1;
                            if (ovf_cnt != {OVF_W{1'b1}}) ovf_cnt <= ovf_cnt + OVF_W'(1);
                        end
                    end
                end
                W_FILL: begin
                    if (wr_start) wr_ack <= 1'b1;
                    else if (wr_commit) wr_state <= W_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_bank_sched.sv
// Scoreboard bench for frame_bank_sched: a frame-count model predicts grants, drops and the
// bank each transmitter should be offered; a monitor checks them as the DUT presents them.
module tb_frame_bank_sched;

    localparam int NB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       wr_start = 1'b0, wr_commit = 1'b0, cc_done = 1'b0, lpc_done = 1'b0;
    logic       lpc_en = 1'b1;
    logic       wr_ack, wr_drop, cc_start, lpc_start;
    logic [1:0] wr_bank, cc_bank, lpc_bank;
    logic [2:0] frames_pend;
    logic [7:0] ovf_cnt;

    always #5 clock = ~clock;

    frame_bank_sched dut (
        .clock       (clock),
        .reset       (reset),
        .wr_start    (wr_start),
        .wr_commit   (wr_commit),
        .wr_ack      (wr_ack),
        .wr_drop     (wr_drop),
        .wr_bank     (wr_bank),
        .cc_start    (cc_start),
        .cc_bank     (cc_bank),
        .cc_done     (cc_done),
        .lpc_en      (lpc_en),
        .lpc_start   (lpc_start),
        .lpc_bank    (lpc_bank),
        .lpc_done    (lpc_done),
        .frames_pend (frames_pend),
        .ovf_cnt     (ovf_cnt)
    );

    int tests = 0;
    int fails = 0;

    // Model: frames counted as integers; bank of frame n is n mod NB.
    int committed = 0, cc_freed = 0, lpc_freed = 0, drops = 0;
    bit filling = 0, cc_busy = 0, lpc_busy = 0;
    int last_cc_bank = -1;
    int wr_q[$];
    int cc_q[$];
    int lpc_q[$];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int model_pend();
        int c = committed - cc_freed;
        int l = lpc_en ? committed - lpc_freed : 0;
        return (c > l) ? c : l;
    endfunction

    function automatic bit quiet();
        return model_pend() == 0 && wr_q.size() == 0 && cc_q.size() == 0 &&
               lpc_q.size() == 0 && !cc_busy && !lpc_busy;
    endfunction

    initial begin : monitor
        int e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                chk("ack_and_drop", int'(wr_ack & wr_drop), 0);
                if (wr_ack || wr_drop) begin
                    if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                    else begin
                        e = wr_q.pop_front();
                        if (e < 0) chk("wr_drop", int'(wr_drop), 1);
                        else begin
                            chk("wr_ack", int'(wr_ack), 1);
                            chk("wr_ack_bank", int'(wr_bank), e);
                        end
                    end
                end
                if (cc_start) begin
                    if (cc_q.size() == 0) chk("cc_unexpected_start", 1, 0);
                    else chk("cc_bank", int'(cc_bank), cc_q.pop_front());
                    cc_busy = 1;
                    last_cc_bank = int'(cc_bank);
                end
                if (lpc_start) begin
                    if (lpc_q.size() == 0) chk("lpc_unexpected_start", 1, 0);
                    else chk("lpc_bank", int'(lpc_bank), lpc_q.pop_front());
                    lpc_busy = 1;
                end
            end
        end
    end

    // One clock of stimulus; inputs change 2 time units after the rising edge.
    task automatic step(input bit ws, input bit wc, input bit cd, input bit ld);
        int p;
        @(posedge clock);
        #2;
        p = model_pend();
        chk("frames_pend", int'(frames_pend), p);
        chk("wr_bank", int'(wr_bank), committed % NB);
        chk("ovf_cnt", int'(ovf_cnt), drops);
        if (!cc_busy) cd = 0;
        if (!lpc_busy) ld = 0;
        if (ws) begin
            if (filling) wr_q.push_back(committed % NB);
            else if (p < NB) begin
                filling = 1;
                wr_q.push_back(committed % NB);
            end else begin
                wr_q.push_back(-1);
                if (drops < 255) drops++;
            end
        end else if (wc && filling) begin
            cc_q.push_back(committed % NB);
            if (lpc_en) lpc_q.push_back(committed % NB);
            committed++;
            filling = 0;
        end
        if (cd) begin cc_freed++; cc_busy = 0; end
        if (ld) begin lpc_freed++; lpc_busy = 0; end
        if (!lpc_en) lpc_freed = committed;
        wr_start = ws; wr_commit = wc; cc_done = cd; lpc_done = ld;
    endtask

    task automatic wait_busy(input bit want_lpc);
        for (int i = 0; i < 20; i++) begin
            if (cc_busy && (!want_lpc || lpc_busy)) return;
            step(0, 0, 0, 0);
        end
        chk("start_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (quiet()) begin
                step(0, 0, 0, 0);
                return;
            end
            step(0, 0, 1, 1);
        end
        chk("drain_timeout", 0, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_wr_ack"}, int'(wr_ack), 0);
        chk({tag, "_wr_drop"}, int'(wr_drop), 0);
        chk({tag, "_wr_bank"}, int'(wr_bank), 0);
        chk({tag, "_cc_start"}, int'(cc_start), 0);
        chk({tag, "_cc_bank"}, int'(cc_bank), 0);
        chk({tag, "_lpc_start"}, int'(lpc_start), 0);
        chk({tag, "_lpc_bank"}, int'(lpc_bank), 0);
        chk({tag, "_frames_pend"}, int'(frames_pend), 0);
        chk({tag, "_ovf_cnt"}, int'(ovf_cnt), 0);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #3;
        reset = 1'b1;
        wr_start = 0; wr_commit = 0; cc_done = 0; lpc_done = 0;
        #1;
        check_zero_outputs("reset");
        committed = 0; cc_freed = 0; lpc_freed = 0; drops = 0;
        filling = 0; cc_busy = 0; lpc_busy = 0;
        wr_q.delete(); cc_q.delete(); lpc_q.delete();
        repeat (2) @(posedge clock);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset state, then idle with no spurious starts
        #13;
        check_zero_outputs("in_reset");
        reset = 1'b0;
        repeat (100) step(0, 0, 0, 0);

        // 2: one frame, both readers, start latency commit+2
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("t2_cc_start_early", int'(cc_start), 0);
        step(0, 0, 0, 0);
        chk("t2_cc_start", int'(cc_start), 1);
        chk("t2_lpc_start", int'(lpc_start), 1);
        chk("t2_cc_bank", int'(cc_bank), 0);
        chk("t2_lpc_bank", int'(lpc_bank), 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        chk("t2_pend_lpc_held", int'(frames_pend), 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("t2_pend_freed", int'(frames_pend), 0);
        drain();

        // 4: LPC disabled, CC alone frees banks
        lpc_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1, 0, 0, 0);
            step(0, 1, 0, 0);
            wait_busy(0);
            step(0, 0, 1, 0);
            step(0, 0, 0, 0);
            chk("t4_pend_zero", int'(frames_pend), 0);
        end
        drain();
        lpc_en = 1'b1;
        step(0, 0, 0, 0);

        // 5: commit coincides with both dones, 9 frames
        for (int k = 0; k < 9; k++) begin
            step(1, 0, 0, 0);
            step(0, 0, 0, 0);
            step(0, 1, cc_busy, lpc_busy);
        end
        drain();
        chk("t5_last_bank", last_cc_bank, (committed - 1) % NB);

        // 6: reset while CC busy and writer filling
        do_reset();
        step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        wait_busy(1);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t6_pre_pend", int'(frames_pend), 1);
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        drain();

        // 3: fill all banks with readers stalled, then overflow and saturation
        do_reset();
        for (int k = 0; k < NB; k++) begin
            step(1, 0, 0, 0);
            step(0, 1, 0, 0);
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t3_ovf_one", int'(ovf_cnt), 1);
        chk("t3_pend_full", int'(frames_pend), NB);
        chk("t3_wr_bank", int'(wr_bank), 0);
        repeat (300) step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("t3_ovf_sat", int'(ovf_cnt), 255);
        drain();

        // Randomised traffic in segments with a random LPC enable
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            lpc_en = 1'($urandom_range(0, 1));
            for (int i = 0; i < 300; i++) begin
                step(filling ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0),
                     filling && ($urandom_range(0, 2) == 0),
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 2) == 0);
            end
            drain();
        end

        chk("final_wr_q_empty", wr_q.size(), 0);
        chk("final_cc_q_empty", cc_q.size(), 0);
        chk("final_lpc_q_empty", lpc_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
